// File: rtl/reg_file_dump_reader.sv
// Read-side dump master for the register file: on a Show_EN rising edge it walks
// addresses 0..NUM_REGS-1 and streams each captured word over a valid/ready port.
module reg_file_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Show_EN,
  output logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_showQ;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_outData;
  logic [ADDR_W-1:0] r_outAddr;
  logic              r_outValid;
  logic              w_start;
  logic              w_accept;
  logic              w_last;

  // Only a fresh rising edge starts a dump; edges seen outside IDLE are dropped.
  assign w_start  = Show_EN & ~r_showQ;
  assign w_accept = r_outValid & out_ready;
  assign w_last   = (r_cnt == LAST_ADDR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_nextState = S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        w_nextState = S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (w_accept) begin
          w_nextState = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Each word is captured at its own READ edge, so later RF writes still show up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_showQ    <= 1'b0;
      r_cnt      <= '0;
      r_outData  <= '0;
      r_outAddr  <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_showQ <= Show_EN;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
          end
        end
        S_READ: begin
          r_outData  <= rd_data;
          r_outAddr  <= r_cnt;
          r_outValid <= 1'b1;
        end
        S_SEND: begin
          if (w_accept) begin
            r_outValid <= 1'b0;
            if (!w_last) begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rd_add    = r_cnt;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_addr  = r_outAddr;

endmodule

// File: doc/reg_file_dump_reader.md
Name: reg_file_dump_reader

Overview:
Read-side master for the 32x32 register file. On a rising edge of Show_EN it walks register addresses 0..NUM_REGS-1 through a dedicated read port, captures each word, and streams it out over a valid/ready interface to the testbench/debug dump sink. This replaces ad-hoc in-RF dump loops with a clocked, back-pressurable reader sitting beside the register file.

Parameters:
NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
CLK  in  1  system clock; all state updates on posedge
RST_N  in  1  asynchronous active-low reset
Show_EN  in  1  dump request; rising edge starts a dump
rd_add  out  ADDR_W  read address to register file read port (combinational read)
rd_data  in  DATA_W  data returned by register file for rd_add, same cycle
out_valid  out  1  out_data/out_addr hold a valid word
out_ready  in  1  sink accepts word when out_valid & out_ready at posedge
out_data  out  DATA_W  captured register value
out_addr  out  ADDR_W  register index of out_data
busy  out  1  high from first READ cycle until DONE cycle inclusive
done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (async, RST_N=0): state=IDLE, cnt=0, show_q=0, rd_add=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. Reset mid-dump aborts immediately; no partial word remains valid after release.
- Edge detect: show_q<=Show_EN every posedge; start = Show_EN & ~show_q. Show_EN held high never retriggers; start while not IDLE is ignored (not queued).
- rd_add = cnt at all times (registered counter, no combinational path from inputs).
- FSM:
  IDLE: out_valid=0, busy=0. On start: cnt<=0, ->READ.
  READ: busy=1. At posedge: out_data<=rd_data, out_addr<=cnt, out_valid<=1, ->SEND.
  SEND: out_valid=1; out_data/out_addr stable while out_ready=0 (hold indefinitely). On out_valid&out_ready: out_valid<=0; if cnt==NUM_REGS-1 ->DONE else cnt<=cnt+1, ->READ.
  DONE: done=1, busy=1 for exactly one cycle; cnt<=0; ->IDLE.
- Latency: start sampled at posedge T -> READ during T..T+1 -> first out_valid high after posedge T+1. With out_ready tied high, one word per 2 cycles; full 32-reg dump = 64 cycles, done pulse in cycle after last handshake.
- Data capture is per-word at the READ posedge, not a snapshot: a register-file write (negedge) landing before a register's READ cycle is reflected in the dump; writes after capture are not.
- Address 0 is dumped like any other; RF guarantees it reads 0.
- cnt wrap: counter never exceeds NUM_REGS-1; no modulo wrap in DATA path.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset then pulse Show_EN with RF preloaded reg[i]=i*16'h0101, out_ready=1 -> 32 words, out_addr 0..31 in order, out_data matches (reg0=0, reg31=32'h1F1F), done pulse exactly once at cycle 65 after start edge.
- Show_EN held high for 200 cycles -> exactly one dump (32 words), no restart after done.
- out_ready toggles 1/0 every 3 cycles -> out_data/out_addr stable while stalled, no duplicated or skipped addresses, total 32 handshakes.
- Second Show_EN rising edge at word 10 -> ignored; dump completes normally; new edge after done starts fresh from addr 0.
- Assert RST_N=0 mid-SEND at addr 17 -> out_valid, busy, done go 0 immediately; after release, idle until next Show_EN edge, then restarts at addr 0.
- RF write reg[20]=32'hDEAD_BEEF during addr 5 transfer -> dumped word for addr 20 equals 32'hDEADBEEF; write to reg[3] at same time leaves already-dumped addr 3 value unchanged.
